// File: rtl/ddr3_avl_arbiter.sv
// Two-master arbiter for the DDR3 Avalon-MM port: port 0 has priority, port 1 is starvation-protected.
// Latency: grant registered in IDLE (one bubble cycle per transaction); bus mux and read-return routing are combinational.
// Backpressure: avl_ready is forwarded to the granted master as pN_ready; a full tag FIFO blocks new reads.
module ddr3_avl_arbiter #(
  parameter int BURST_LEN    = 4,
  parameter int TAG_DEPTH    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          ddr3_clk,
  input  logic          reset_n,
  input  logic          p0_read_req,
  input  logic          p0_write_req,
  input  logic [25:0]   p0_addr,
  input  logic          p0_burstbegin,
  input  logic [127:0]  p0_wdata,
  output logic          p0_ready,
  output logic          p0_rdata_valid,
  input  logic          p1_read_req,
  input  logic          p1_write_req,
  input  logic [25:0]   p1_addr,
  input  logic          p1_burstbegin,
  input  logic [127:0]  p1_wdata,
  output logic          p1_ready,
  output logic          p1_rdata_valid,
  output logic [127:0]  rdata,
  input  logic          avl_ready,
  input  logic [127:0]  avl_rdata,
  input  logic          avl_rdata_valid,
  output logic          avl_read_req,
  output logic          avl_write_req,
  output logic          avl_burstbegin,
  output logic [25:0]   avl_addr,
  output logic [127:0]  avl_wdata,
  output logic [2:0]    avl_size,
  output logic          tag_err
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_LEN - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [PW:0]   TAG_FULL   = (PW + 1)'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, GNT_RD, GNT_WR} state_t;

  state_t          state, state_nxt;
  logic            grant, grant_nxt;
  logic [SW-1:0]   starve_cnt, starve_nxt;
  logic [BW-1:0]   beat_cnt, beat_nxt;
  logic [BW-1:0]   rbeat_cnt;

  logic            tag_mem [TAG_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     tag_cnt;
  logic            tag_full, tag_empty, tag_head, tag_push, tag_pop;

  logic            elig0, elig1, pick1, pick_wr;
  logic            g_read, g_write, g_bb;
  logic [25:0]     g_addr;
  logic [127:0]    g_wdata;

  assign tag_empty = (tag_cnt == '0);
  assign tag_full  = (tag_cnt == TAG_FULL);
  assign tag_head  = tag_mem[rd_ptr];

  // A read can only be taken if there is a tag slot to remember its owner.
  assign elig0 = p0_write_req || (p0_read_req && !tag_full);
  assign elig1 = p1_write_req || (p1_read_req && !tag_full);

  assign g_read  = grant ? p1_read_req   : p0_read_req;
  assign g_write = grant ? p1_write_req  : p0_write_req;
  assign g_bb    = grant ? p1_burstbegin : p0_burstbegin;
  assign g_addr  = grant ? p1_addr       : p0_addr;
  assign g_wdata = grant ? p1_wdata      : p0_wdata;

  assign avl_size = 3'(BURST_LEN);

  // Read return: route each beat to the owner of the oldest outstanding burst; orphan beats are dropped.
  assign rdata          = avl_rdata;
  assign p0_rdata_valid = avl_rdata_valid && !tag_empty && !tag_head;
  assign p1_rdata_valid = avl_rdata_valid && !tag_empty &&  tag_head;
  assign tag_pop        = avl_rdata_valid && !tag_empty && (rbeat_cnt == LAST_BEAT);

  // FSM state and arbitration bookkeeping registers.
  always_ff @(posedge ddr3_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      starve_cnt <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      starve_cnt <= starve_nxt;
      beat_cnt   <= beat_nxt;
    end
  end

  // Arbitration, bus mux and per-port ready; the loser is fully masked while a grant is held.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    starve_nxt     = starve_cnt;
    beat_nxt       = beat_cnt;
    tag_push       = 1'b0;
    pick1          = 1'b0;
    pick_wr        = 1'b0;
    avl_read_req   = 1'b0;
    avl_write_req  = 1'b0;
    avl_burstbegin = 1'b0;
    avl_addr       = '0;
    avl_wdata      = '0;
    p0_ready       = 1'b0;
    p1_ready       = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          pick1     = elig1 && (!elig0 || (starve_cnt == STARVE_MAX));
          pick_wr   = pick1 ? p1_write_req : p0_write_req;
          grant_nxt = pick1;
          state_nxt = pick_wr ? GNT_WR : GNT_RD;
          if (pick1)
            starve_nxt = '0;
          else if (elig1 && (starve_cnt != STARVE_MAX))
            starve_nxt = starve_cnt + 1'b1;
        end
      end
      GNT_RD: begin
        avl_read_req   = g_read;
        avl_burstbegin = g_bb;
        avl_addr       = g_addr;
        avl_wdata      = g_wdata;
        p0_ready       = avl_ready && !grant && p0_read_req;
        p1_ready       = avl_ready &&  grant && p1_read_req;
        if (g_read && avl_ready) begin
          tag_push  = 1'b1;
          state_nxt = IDLE;
        end
      end
      GNT_WR: begin
        avl_write_req  = g_write;
        avl_burstbegin = g_bb;
        avl_addr       = g_addr;
        avl_wdata      = g_wdata;
        p0_ready       = avl_ready && !grant && p0_write_req;
        p1_ready       = avl_ready &&  grant && p1_write_req;
        if (g_write && avl_ready) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            beat_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tag FIFO pointers, occupancy, return-beat counter and sticky orphan-beat flag.
  always_ff @(posedge ddr3_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_cnt   <= '0;
      rbeat_cnt <= '0;
      tag_err   <= 1'b0;
    end else begin
      if (tag_push) wr_ptr <= wr_ptr + 1'b1;
      if (tag_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
      if (avl_rdata_valid && !tag_empty)
        rbeat_cnt <= (rbeat_cnt == LAST_BEAT) ? '0 : rbeat_cnt + 1'b1;
      if (avl_rdata_valid && tag_empty)
        tag_err <= 1'b1;
    end
  end

  // Tag storage: the owning port id of each accepted read command.
  always_ff @(posedge ddr3_clk) begin
    if (tag_push) tag_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Bench for ddr3_avl_arbiter: vector table for single/contended transactions,
// hand sequences for starvation, tag-FIFO full, write stalls, orphan beats and reset.
// Read-return ownership and write data are tracked in scoreboard queues.
module tb_ddr3_avl_arbiter;

  logic          ddr3_clk;
  logic          reset_n;
  logic          p0_read_req, p0_write_req, p0_burstbegin;
  logic [25:0]   p0_addr;
  logic [127:0]  p0_wdata;
  logic          p0_ready, p0_rdata_valid;
  logic          p1_read_req, p1_write_req, p1_burstbegin;
  logic [25:0]   p1_addr;
  logic [127:0]  p1_wdata;
  logic          p1_ready, p1_rdata_valid;
  logic [127:0]  rdata;
  logic          avl_ready;
  logic [127:0]  avl_rdata;
  logic          avl_rdata_valid;
  logic          avl_read_req, avl_write_req, avl_burstbegin;
  logic [25:0]   avl_addr;
  logic [127:0]  avl_wdata;
  logic [2:0]    avl_size;
  logic          tag_err;

  int checks   = 0;
  int failures = 0;
  int beat_seq = 0;

  int           exp_port_q[$];
  int           exp_evt[$];
  logic [127:0] wq[$];

  typedef struct {
    logic [6:0]  in;    // {p0_rd, p0_wr, p0_bb, p1_rd, p1_wr, p1_bb, avl_ready}
    logic [4:0]  ex;    // {avl_read_req, avl_write_req, avl_burstbegin, p0_ready, p1_ready}
    logic [25:0] addr;  // expected avl_addr
  } vec_t;
  vec_t tbl[$];

  ddr3_avl_arbiter #(.BURST_LEN(4), .TAG_DEPTH(8), .STARVE_LIMIT(4)) dut (
    .ddr3_clk(ddr3_clk), .reset_n(reset_n),
    .p0_read_req(p0_read_req), .p0_write_req(p0_write_req), .p0_addr(p0_addr),
    .p0_burstbegin(p0_burstbegin), .p0_wdata(p0_wdata), .p0_ready(p0_ready),
    .p0_rdata_valid(p0_rdata_valid),
    .p1_read_req(p1_read_req), .p1_write_req(p1_write_req), .p1_addr(p1_addr),
    .p1_burstbegin(p1_burstbegin), .p1_wdata(p1_wdata), .p1_ready(p1_ready),
    .p1_rdata_valid(p1_rdata_valid),
    .rdata(rdata), .avl_ready(avl_ready), .avl_rdata(avl_rdata),
    .avl_rdata_valid(avl_rdata_valid), .avl_read_req(avl_read_req),
    .avl_write_req(avl_write_req), .avl_burstbegin(avl_burstbegin),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_size(avl_size), .tag_err(tag_err)
  );

  initial ddr3_clk = 1'b0;
  always #5 ddr3_clk = ~ddr3_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk1(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask

  task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Advance to 2 time units after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge ddr3_clk);
    #2;
  endtask

  task automatic push_port(input int port);
    for (int k = 0; k < 4; k++) exp_port_q.push_back(port);
  endtask

  // Drive n returned beats; each beat's owner comes from the scoreboard (none if empty).
  task automatic ret_beats(input int n);
    for (int i = 0; i < n; i++) begin
      int port;
      logic [127:0] d;
      beat_seq++;
      d = {96'hD0D0_0000_0000_0000_0000_0000, 32'(beat_seq)};
      port = (exp_port_q.size() > 0) ? exp_port_q.pop_front() : -1;
      avl_rdata_valid = 1'b1;
      avl_rdata = d;
      #1;
      chk1($sformatf("ret%0d_p0_rdata_valid", beat_seq), p0_rdata_valid, port == 0);
      chk1($sformatf("ret%0d_p1_rdata_valid", beat_seq), p1_rdata_valid, port == 1);
      chkv($sformatf("ret%0d_rdata", beat_seq), rdata, d);
      cyc();
    end
    avl_rdata_valid = 1'b0;
  endtask

  // Issue one read burst from a port and wait (bounded) for its acceptance.
  task automatic issue_read(input int port, input logic [25:0] a);
    int n;
    n = 0;
    if (port == 0) begin p0_read_req = 1'b1; p0_burstbegin = 1'b1; p0_addr = a; end
    else           begin p1_read_req = 1'b1; p1_burstbegin = 1'b1; p1_addr = a; end
    push_port(port);
    #1;
    while (!(port == 0 ? p0_ready : p1_ready) && n < 20) begin
      cyc();
      #1;
      n++;
    end
    chk1($sformatf("issue_p%0d_ready", port), port == 0 ? p0_ready : p1_ready, 1'b1);
    chkv($sformatf("issue_p%0d_addr", port), 128'(avl_addr), 128'(a));
    chk1($sformatf("issue_p%0d_avl_read_req", port), avl_read_req, 1'b1);
    cyc();
    p0_read_req = 1'b0; p0_burstbegin = 1'b0;
    p1_read_req = 1'b0; p1_burstbegin = 1'b0;
  endtask

  int nbeats = 0;
  task automatic wr_sample();
    if (p1_ready) begin
      nbeats++;
      if (wq.size() > 0) chkv($sformatf("wr_wdata_beat%0d", nbeats), avl_wdata, wq.pop_front());
    end
  endtask

  initial begin
    // vectors: {inputs, expected outputs, expected addr}
    tbl.push_back('{7'b1010001, 5'b00000, 26'h0});       // p0 read alone: IDLE arbitrates
    tbl.push_back('{7'b1010001, 5'b10110, 26'h0000040}); // command on next cycle
    tbl.push_back('{7'b0000001, 5'b00000, 26'h0});
    tbl.push_back('{7'b1010111, 5'b00000, 26'h0});       // p0 read + p1 write together
    tbl.push_back('{7'b1010111, 5'b10110, 26'h0000040}); // p0 wins
    tbl.push_back('{7'b0000111, 5'b00000, 26'h0});       // bubble
    tbl.push_back('{7'b0000111, 5'b01101, 26'h0100000}); // p1 beat 1 with burstbegin
    tbl.push_back('{7'b0000101, 5'b01001, 26'h0100000});
    tbl.push_back('{7'b0000101, 5'b01001, 26'h0100000});
    tbl.push_back('{7'b0000101, 5'b01001, 26'h0100000}); // beat 4
    tbl.push_back('{7'b0000001, 5'b00000, 26'h0});

    reset_n = 1'b0;
    p0_read_req = 0; p0_write_req = 0; p0_burstbegin = 0; p0_addr = '0; p0_wdata = '0;
    p1_read_req = 0; p1_write_req = 0; p1_burstbegin = 0; p1_addr = '0; p1_wdata = '0;
    avl_ready = 0; avl_rdata = '0; avl_rdata_valid = 0;
    #1;
    chk1("rst_avl_read_req", avl_read_req, 1'b0);
    chk1("rst_avl_write_req", avl_write_req, 1'b0);
    chkv("rst_avl_size", 128'(avl_size), 128'(4));
    chk1("rst_tag_err", tag_err, 1'b0);
    repeat (2) @(posedge ddr3_clk);
    #2;
    reset_n = 1'b1;
    #1;
    chk1("rst_p0_ready", p0_ready, 1'b0);
    chk1("rst_p1_ready", p1_ready, 1'b0);
    chkv("rst_avl_addr", 128'(avl_addr), 128'(0));
    cyc();

    // Table: single read, then contended read/write.
    p0_addr = 26'h0000040; p1_addr = 26'h0100000;
    p0_wdata = {4{32'hAAAA_0000}}; p1_wdata = {4{32'h5555_1111}};
    foreach (tbl[i]) begin
      {p0_read_req, p0_write_req, p0_burstbegin, p1_read_req, p1_write_req, p1_burstbegin, avl_ready} = tbl[i].in;
      #1;
      chk1($sformatf("tbl%0d_avl_read_req", i), avl_read_req, tbl[i].ex[4]);
      chk1($sformatf("tbl%0d_avl_write_req", i), avl_write_req, tbl[i].ex[3]);
      chk1($sformatf("tbl%0d_avl_burstbegin", i), avl_burstbegin, tbl[i].ex[2]);
      chk1($sformatf("tbl%0d_p0_ready", i), p0_ready, tbl[i].ex[1]);
      chk1($sformatf("tbl%0d_p1_ready", i), p1_ready, tbl[i].ex[0]);
      chkv($sformatf("tbl%0d_avl_addr", i), 128'(avl_addr), 128'(tbl[i].addr));
      if (tbl[i].ex[1] && tbl[i].in[6]) push_port(0);
      if (tbl[i].ex[0] && tbl[i].in[3]) push_port(1);
      cyc();
    end
    p0_read_req = 0; p0_burstbegin = 0; p1_write_req = 0; p1_burstbegin = 0;
    ret_beats(8);

    // Starvation: p0 reads back to back while p1 holds a write request.
    exp_evt = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    foreach (exp_evt[i]) if (exp_evt[i] == 0) push_port(0);
    begin
      int wbeat, nw, ncyc;
      wbeat = 0; nw = 0; ncyc = 0;
      p0_read_req = 1; p0_burstbegin = 1;
      while (exp_evt.size() > 0 && ncyc < 80) begin
        int ev;
        ev = -1;
        p1_write_req  = (nw < 2);
        p1_burstbegin = (wbeat == 0);
        #1;
        if (p0_ready) ev = 0;
        if (p1_ready) begin
          wbeat++;
          if (wbeat == 4) begin wbeat = 0; nw++; ev = 1; end
        end
        if (ev >= 0) chkv($sformatf("starve_evt_left%0d", exp_evt.size()), 128'(ev), 128'(exp_evt.pop_front()));
        cyc();
        ncyc++;
      end
      chkv("starve_events_missing", 128'(exp_evt.size()), 128'(0));
      p1_write_req = 0; p1_burstbegin = 0;
    end

    // Tag FIFO now full: further p0 reads stall.
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1($sformatf("full_stall%0d_avl_read_req", i), avl_read_req, 1'b0);
      chk1($sformatf("full_stall%0d_p0_ready", i), p0_ready, 1'b0);
      cyc();
    end
    ret_beats(4);
    #1;
    chk1("full_free_arb_cycle", avl_read_req, 1'b0);
    cyc();
    #1;
    chk1("full_free_avl_read_req", avl_read_req, 1'b1);
    chk1("full_free_p0_ready", p0_ready, 1'b1);
    push_port(0);
    cyc();
    p0_read_req = 0; p0_burstbegin = 0;
    ret_beats(32);

    // Interleaved owners.
    issue_read(1, 26'h0000200);
    issue_read(0, 26'h0000300);
    issue_read(1, 26'h0000400);
    ret_beats(12);

    // Write burst with avl_ready stall, mid-burst request drop, and p0 waiting.
    wq.push_back({4{32'h1111_0000}}); wq.push_back({4{32'h2222_0001}});
    wq.push_back({4{32'h3333_0002}}); wq.push_back({4{32'h4444_0003}});
    p1_addr = 26'h0ABCDE; p1_write_req = 1; p1_burstbegin = 1; p1_wdata = {4{32'h1111_0000}}; avl_ready = 1;
    #1; chk1("wr_arb_cycle", avl_write_req, 1'b0); wr_sample(); cyc();
    #1; chk1("wr_b1_burstbegin", avl_burstbegin, 1'b1); chkv("wr_b1_addr", 128'(avl_addr), 128'(26'h0ABCDE));
    chk1("wr_b1_p1_ready", p1_ready, 1'b1); wr_sample(); cyc();
    p0_read_req = 1; p0_burstbegin = 1; p1_burstbegin = 0; p1_wdata = {4{32'h2222_0001}}; avl_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1($sformatf("wr_stall%0d_p1_ready", i), p1_ready, 1'b0);
      chk1($sformatf("wr_stall%0d_avl_write_req", i), avl_write_req, 1'b1);
      chkv($sformatf("wr_stall%0d_wdata", i), avl_wdata, {4{32'h2222_0001}});
      chk1($sformatf("wr_stall%0d_p0_ready", i), p0_ready, 1'b0);
      wr_sample(); cyc();
    end
    avl_ready = 1;
    #1; chk1("wr_b2_p1_ready", p1_ready, 1'b1); wr_sample(); cyc();
    p1_write_req = 0;
    #1; chk1("wr_drop_avl_read_req", avl_read_req, 1'b0); chk1("wr_drop_p0_ready", p0_ready, 1'b0);
    chk1("wr_drop_avl_write_req", avl_write_req, 1'b0); wr_sample(); cyc();
    p1_write_req = 1; p1_wdata = {4{32'h3333_0002}};
    #1; chk1("wr_b3_p1_ready", p1_ready, 1'b1); wr_sample(); cyc();
    p1_wdata = {4{32'h4444_0003}};
    #1; chk1("wr_b4_p1_ready", p1_ready, 1'b1); wr_sample(); cyc();
    p1_write_req = 0;
    #1; chk1("wr_after_bubble", avl_read_req, 1'b0); wr_sample(); cyc();
    #1; chk1("wr_after_p0_read", avl_read_req, 1'b1); chk1("wr_after_p0_ready", p0_ready, 1'b1);
    push_port(0); cyc();
    p0_read_req = 0; p0_burstbegin = 0;
    chkv("wr_beat_total", 128'(nbeats), 128'(4));
    ret_beats(4);

    // Orphan beat with an empty tag FIFO.
    #1; chk1("orphan_tag_err_before", tag_err, 1'b0);
    ret_beats(1);
    #1; chk1("orphan_tag_err_set", tag_err, 1'b1);
    cyc(); cyc();
    #1; chk1("orphan_tag_err_sticky", tag_err, 1'b1);
    cyc();

    // Reset in the middle of a write burst with one read outstanding.
    issue_read(0, 26'h0000500);
    p1_addr = 26'h0000600; p1_write_req = 1; p1_burstbegin = 1;
    cyc();
    #1; chk1("rstwr_b1_avl_write_req", avl_write_req, 1'b1);
    cyc();
    p1_burstbegin = 0;
    #1; chk1("rstwr_b2_avl_write_req", avl_write_req, 1'b1);
    reset_n = 0;
    exp_port_q.delete();
    #1;
    chk1("rstwr_avl_write_req", avl_write_req, 1'b0);
    chk1("rstwr_p1_ready", p1_ready, 1'b0);
    chkv("rstwr_avl_addr", 128'(avl_addr), 128'(0));
    chkv("rstwr_avl_wdata", avl_wdata, 128'(0));
    chk1("rstwr_tag_err", tag_err, 1'b0);
    chkv("rstwr_avl_size", 128'(avl_size), 128'(4));
    cyc();
    p1_write_req = 0;
    reset_n = 1;
    cyc();
    ret_beats(1);
    #1; chk1("rstwr_fifo_empty_tag_err", tag_err, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr3_avl_arbiter.md
Name: ddr3_avl_arbiter

Overview:
- Two-port arbiter sharing the single DDR3 Avalon-MM port between two burst masters: port 0 (display line reader, high priority) and port 1 (frame fill/writer).
- Grants one whole transaction at a time: a read command, or a full write burst.
- Muxes the granted master onto the controller.
- Tracks outstanding read bursts in a tag FIFO so that returned read beats reach the master that issued them.

Parameters:
- BURST_LEN, 4: beats per burst; drives avl_size, the write-beat count and the read-beat count.
- TAG_DEPTH, 8: maximum outstanding read bursts (power of 2).
- STARVE_LIMIT, 4: consecutive port-0 grants while port 1 waits, after which port 1 is forced.

Ports:
- ddr3_clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- pN_read_req  in  1  port N (N=0,1) read command request
- pN_write_req  in  1  port N write beat request
- pN_addr  in  26  port N burst address; sampled with the command or the first write beat
- pN_burstbegin  in  1  port N burstbegin
- pN_wdata  in  128  port N write data
- pN_ready  out  1  port N command/beat accepted this cycle
- pN_rdata_valid  out  1  returned read beat belongs to port N
- rdata  out  128  avl_rdata broadcast to both ports
- avl_ready  in  1  controller ready
- avl_rdata  in  128  controller read data
- avl_rdata_valid  in  1  controller read beat valid
- avl_read_req  out  1  controller read request
- avl_write_req  out  1  controller write request
- avl_burstbegin  out  1  controller burstbegin
- avl_addr  out  26  controller address
- avl_wdata  out  128  controller write data
- avl_size  out  3  constant BURST_LEN
- tag_err  out  1  sticky: read beat returned with no tag outstanding

Behaviour:
- Reset (asynchronous): state=IDLE, grant=0, starve_cnt=0, beat_cnt=0, tag FIFO empty, rbeat_cnt=0, tag_err=0. All avl_* and pN_* outputs are 0, except avl_size, which stays BURST_LEN.
- States:
  - IDLE: arbitrate.
  - GNT_RD: the granted port drives the bus until its read command is accepted.
  - GNT_WR: the granted port drives the bus until BURST_LEN write beats are accepted.
- Eligibility:
  - Port N is eligible if pN_write_req=1.
  - Port N is also eligible if pN_read_req=1 and the tag FIFO is not full.
  - If a port asserts both requests, write is selected.
- Arbitration in IDLE (registered; the grant takes effect next cycle):
  - Port 0 wins when both ports are eligible, unless starve_cnt==STARVE_LIMIT, in which case port 1 wins.
  - starve_cnt increments on each port-0 grant while port 1 is eligible.
  - starve_cnt clears on any port-1 grant.
  - starve_cnt saturates at STARVE_LIMIT.
  - No eligible port: stay in IDLE, avl_* requests stay 0.
- While granted:
  - avl_read_req/write_req/burstbegin/addr/wdata are combinationally passed from the granted port.
  - The non-granted port sees pN_ready=0 and is masked from the bus.
  - pN_ready = avl_ready & granted(N) & (state matches the request type).
- Read acceptance (avl_read_req & avl_ready): push the port id into the tag FIFO, then go to IDLE.
- Write acceptance:
  - Each avl_write_req & avl_ready increments beat_cnt.
  - On the BURST_LEN-th beat, clear beat_cnt and go to IDLE.
  - If the master drops write_req mid-burst, the grant is held (no other port may interleave).
- Arbitration bubble: exactly one IDLE cycle between consecutive transactions.
- Read return:
  - On avl_rdata_valid, pN_rdata_valid=1 for N equal to the FIFO head; this path is combinational and has zero latency.
  - rbeat_cnt increments per beat; on the BURST_LEN-th beat the FIFO pops and rbeat_cnt clears.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Tag FIFO full: reads are ineligible.
- avl_rdata_valid while the tag FIFO is empty: the beat is dropped (no pN_rdata_valid) and tag_err is set until reset.

Test Plan:
- Port-0 read at addr 0x000040 alone → avl_read_req with avl_addr=0x000040 on the cycle after the request. 4 returned beats D0..D3 → p0_rdata_valid for 4 cycles, p1_rdata_valid=0.
- Simultaneous p0 read and p1 write (4 beats, addr 0x100000) → p0 is granted first; after the bubble, p1 writes 4 beats with burstbegin on beat 1 only, avl_addr=0x100000.
- Port 0 reads continuously while port 1 holds write_req → port 1 is granted after exactly 4 port-0 grants, and starve_cnt returns to 0.
- avl_ready low for 3 cycles during the 2nd write beat → beat held stable, p1_ready=0 for those cycles, still 4 beats total, no port-0 interleave.
- 8 reads issued with no return data → the 9th read stalls. One complete 4-beat return frees a slot → the read is granted on the next IDLE cycle. Interleaved p0/p1 tags route the beats to the correct ports.
- avl_rdata_valid pulse with the FIFO empty → tag_err=1 and stays set. reset_n asserted mid write burst → all outputs 0 immediately and FIFO empty.
